buffer_rd_stream: RTL and testbench
===================================

Name: buffer_rd_stream

Overview:
Read-side drain engine for the asymmetric frame buffer. It sits directly downstream of the buffer's wide (16-bit) port B. On a start command it issues sequential read addresses from a base address for a programmed word count. It absorbs the buffer's one-cycle read latency in a 2-entry skid FIFO and presents the words as a valid/ready stream with a last flag. Consumers are the bus/DMA side of the SoC. Port B is used read-only; the buffer's write enable is held low.

Parameters:
WIDTHB, 16, data width of buffer port B and of the output stream
ADDRWIDTHB, 8, address width of buffer port B; the address space is 2^ADDRWIDTHB words

Ports:
buffer_clk  in  1  single clock, rising edge
buffer_rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle command pulse; sampled only when busy=0
base_addr  in  ADDRWIDTHB  first word address, sampled with start
word_cnt  in  ADDRWIDTHB+1  number of words to read, sampled with start; 0 is legal
buffer_addr_b  out  ADDRWIDTHB  read address to buffer port B (registered)
buffer_we_b  out  1  constant 0
buffer_dout_b  in  WIDTHB  buffer read data, valid the cycle after the address is sampled
m_data  out  WIDTHB  stream data (FIFO head)
m_valid  out  1  stream valid
m_last  out  1  marks the final word of the command
m_ready  in  1  downstream ready
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at command completion

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. buffer_rst_n low forces all of the following immediately, independent of the clock:
  - state=IDLE; buffer_addr_b=0; buffer_we_b=0
  - m_valid=0, m_last=0, m_data=0
  - busy=0, done=0
  - FIFO count, pending flag and remaining counter all 0
- Reset mid-command: in-flight read data is discarded. No done pulse is produced.
- States:
  - IDLE: start=1 latches base_addr and word_cnt, sets busy=1. If word_cnt=0, go to DONE; otherwise go to RUN. Start while busy=1 is ignored.
  - RUN: issue reads. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the last word is accepted.
  - DONE: assert done=1 for exactly one cycle, clear busy, return to IDLE. DONE also follows DRAIN on the edge where the last word is accepted.
- Read issue:
  - issue = (state==RUN) and (remaining != 0) and (fifo_cnt + pending - pop) < 2, where pop = m_valid & m_ready.
  - On issue: buffer_addr_b <= current address; pending <= 1 for the next cycle; address increments modulo 2^ADDRWIDTHB (wraps from all-ones to 0); remaining decrements.
- Capture: in the cycle after issue, buffer_dout_b is written into the FIFO tail at the clock edge. The word's last tag is set if it was the final issued read.
- Latency: with start sampled at edge E0 and m_ready=1, the first m_valid is high after edge E2. Sustained throughput is 1 word/cycle while m_ready=1.
- Stream rules:
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_last=1 only on the final word.
- Backpressure: when m_ready=0, FIFO plus in-flight never exceeds 2 entries. No data loss, no duplication.
- FIFO push and pop in the same cycle: the count is unchanged.
- done asserts on the cycle after the edge on which the last handshake occurs.
- word_cnt: values up to 2^ADDRWIDTHB read the whole buffer. Larger values wrap and re-read addresses.

Test Plan:
- Reset, then start with base_addr=0x10, word_cnt=4, m_ready=1 (buffer preloaded with 0x1000+addr) -> m_data 0x1010, 0x1011, 0x1012, 0x1013 on consecutive cycles. First m_valid 2 edges after start. m_last on 0x1013. done one cycle later; busy high throughout.
- base_addr=0xFE, word_cnt=4 -> addresses 0xFE, 0xFF, 0x00, 0x01; data order matches.
- word_cnt=8 with m_ready toggled 1,0,0,1,0,1… randomly -> all 8 words in order. No duplicates. m_data held stable while stalled. Never more than 2 outstanding entries.
- word_cnt=0 -> busy high for one cycle, done pulse, m_valid never asserts.
- Start pulse while busy -> ignored; original transfer completes unchanged.
- Assert buffer_rst_n=0 mid-transfer, with m_ready=0 and FIFO full -> all outputs 0 immediately. After release a new start behaves like the first scenario.

Source files
------------

// File: rtl/buffer_rd_stream.sv
// Read-side drain engine for the frame buffer's wide port B.
// Streams word_cnt words from base_addr through a 2-entry skid FIFO.
module buffer_rd_stream #(
  parameter int WIDTHB     = 16,
  parameter int ADDRWIDTHB = 8
) (
  input  logic                  buffer_clk,
  input  logic                  buffer_rst_n,
  input  logic                  start,
  input  logic [ADDRWIDTHB-1:0] base_addr,
  input  logic [ADDRWIDTHB:0]   word_cnt,
  output logic [ADDRWIDTHB-1:0] buffer_addr_b,
  output logic                  buffer_we_b,
  input  logic [WIDTHB-1:0]     buffer_dout_b,
  output logic [WIDTHB-1:0]     m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDRWIDTHB-1:0] A_ONE = 1;
  localparam logic [ADDRWIDTHB:0]   C_ONE = 1;
  localparam logic [ADDRWIDTHB:0]   C_ZERO = 0;

  state_t                state;
  logic [ADDRWIDTHB-1:0] cur_addr;
  logic [ADDRWIDTHB:0]   remaining;
  logic                  pending;
  logic                  pend_last;

  logic [WIDTHB-1:0]     fifo_d [2];
  logic [1:0]            fifo_l;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign buffer_we_b = 1'b0;
  assign m_valid     = (fifo_cnt != 2'd0);
  assign m_data      = fifo_d[rd_ptr];
  assign m_last      = m_valid & fifo_l[rd_ptr];
  assign pop         = m_valid & m_ready;

  // Entries held plus the read in flight, after this cycle's pop.
  assign occ   = {1'b0, fifo_cnt} + {2'b0, pending} - {2'b0, pop};
  assign issue = (state == RUN) && (remaining != C_ZERO) && (occ < 3'd2);

  always_ff @(posedge buffer_clk or negedge buffer_rst_n) begin
    if (!buffer_rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      buffer_addr_b <= '0;
      pending       <= 1'b0;
      pend_last     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      pending   <= issue;
      pend_last <= issue && (remaining == C_ONE);
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= word_cnt;
            busy      <= 1'b1;
            if (word_cnt == C_ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            buffer_addr_b <= cur_addr;
            cur_addr      <= cur_addr + A_ONE;
            remaining     <= remaining - C_ONE;
            if (remaining == C_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge buffer_clk or negedge buffer_rst_n) begin
    if (!buffer_rst_n) begin
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_l    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      if (pending) begin
        fifo_d[wr_ptr] <= buffer_dout_b;
        fifo_l[wr_ptr] <= pend_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, pending} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_buffer_rd_stream.sv
// Directed bench for buffer_rd_stream with a combinational-read
// buffer model holding 0x1000+addr at every address.
module tb_buffer_rd_stream;

  logic        buffer_clk = 1'b0;
  logic        buffer_rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_cnt;
  logic [7:0]  buffer_addr_b;
  logic        buffer_we_b;
  logic [15:0] buffer_dout_b;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [256];

  int vec = 0;
  int bad = 0;

  always #5 buffer_clk = ~buffer_clk;

  assign buffer_dout_b = mem[buffer_addr_b];

  buffer_rd_stream #(.WIDTHB(16), .ADDRWIDTHB(8)) dut (
    .buffer_clk    (buffer_clk),
    .buffer_rst_n  (buffer_rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_cnt      (word_cnt),
    .buffer_addr_b (buffer_addr_b),
    .buffer_we_b   (buffer_we_b),
    .buffer_dout_b (buffer_dout_b),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .done          (done)
  );

  task automatic check_idle_outputs(input string tag);
    vec++;
    if (buffer_addr_b !== 8'h00) begin
      bad++;
      $display("FAIL %s addr: got %h want 00", tag, buffer_addr_b);
    end
    vec++;
    if (buffer_we_b !== 1'b0) begin
      bad++;
      $display("FAIL %s we: got %b want 0", tag, buffer_we_b);
    end
    vec++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL %s valid/last: got %b/%b want 0/0", tag, m_valid, m_last);
    end
    vec++;
    if (m_data !== 16'h0000) begin
      bad++;
      $display("FAIL %s data: got %h want 0000", tag, m_data);
    end
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s busy/done: got %b/%b want 0/0", tag, busy, done);
    end
  endtask

  task automatic start_cmd(input logic [7:0] b, input logic [8:0] c);
    @(negedge buffer_clk);
    start     = 1'b1;
    base_addr = b;
    word_cnt  = c;
    @(negedge buffer_clk);
    start = 1'b0;
  endtask

  // Called on the first falling edge after the start edge (k=1).
  task automatic collect(input string tag, input logic [7:0] base,
                         input int n, input bit rnd, input int glitch_k,
                         input bit timing);
    int          idx;
    int          first_k;
    int          done_k;
    logic        prev_v;
    logic        prev_hs;
    logic [15:0] prev_d;
    logic        prev_l;
    logic [7:0]  a;
    logic [15:0] exp_d;
    idx = 0; first_k = -1; done_k = -1;
    prev_v = 1'b0; prev_hs = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (prev_v && !prev_hs) begin
        vec++;
        if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
          bad++;
          $display("FAIL %s stall_hold k=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   tag, k, m_valid, m_data, m_last, prev_d, prev_l);
        end
      end
      vec++;
      if (busy !== 1'b1 || buffer_we_b !== 1'b0) begin
        bad++;
        $display("FAIL %s busy k=%0d: got busy=%b we=%b want 1/0", tag, k, busy, buffer_we_b);
      end
      start = (k == glitch_k);
      if (k == glitch_k) begin
        base_addr = 8'h80;
        word_cnt  = 9'd2;
      end
      m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid && first_k < 0) first_k = k;
      if (m_valid && m_ready) begin
        a     = base + idx[7:0];
        exp_d = 16'h1000 + {8'h00, a};
        vec++;
        if (m_data !== exp_d) begin
          bad++;
          $display("FAIL %s data[%0d]: got %h want %h", tag, idx, m_data, exp_d);
        end
        vec++;
        if (m_last !== (idx == n - 1)) begin
          bad++;
          $display("FAIL %s last[%0d]: got %b want %b", tag, idx, m_last, (idx == n - 1));
        end
        idx++;
      end
      prev_v  = m_valid;
      prev_hs = m_valid && m_ready;
      prev_d  = m_data;
      prev_l  = m_last;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge buffer_clk);
    end
    start   = 1'b0;
    m_ready = 1'b1;
    vec++;
    if (done_k < 0) begin
      bad++;
      $display("FAIL %s timeout: got no done want done within 300 cycles", tag);
    end
    vec++;
    if (idx != n) begin
      bad++;
      $display("FAIL %s count: got %0d words want %0d", tag, idx, n);
    end
    if (timing) begin
      vec++;
      if (first_k != 3) begin
        bad++;
        $display("FAIL %s first_valid: got k=%0d want k=3", tag, first_k);
      end
      vec++;
      if (done_k != n + 3) begin
        bad++;
        $display("FAIL %s done_time: got k=%0d want k=%0d", tag, done_k, n + 3);
      end
    end
    @(negedge buffer_clk);
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got busy=%b done=%b valid=%b want 0/0/0",
               tag, busy, done, m_valid);
    end
  endtask

  task automatic test_reset;
    buffer_rst_n = 1'b0;
    start = 1'b0; base_addr = '0; word_cnt = '0; m_ready = 1'b1;
    repeat (2) @(negedge buffer_clk);
    check_idle_outputs("reset");
    buffer_rst_n = 1'b1;
    @(negedge buffer_clk);
  endtask

  task automatic test_basic;
    start_cmd(8'h10, 9'd4);
    collect("basic", 8'h10, 4, 1'b0, 0, 1'b1);
  endtask

  task automatic test_wrap;
    start_cmd(8'hFE, 9'd4);
    collect("wrap", 8'hFE, 4, 1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure;
    start_cmd(8'h30, 9'd8);
    collect("bp", 8'h30, 8, 1'b1, 0, 1'b0);
  endtask

  task automatic test_zero;
    start_cmd(8'h55, 9'd0);
    collect("zero", 8'h55, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy;
    start_cmd(8'h40, 9'd4);
    collect("busy_start", 8'h40, 4, 1'b0, 2, 1'b1);
  endtask

  task automatic test_reset_mid;
    start_cmd(8'h20, 9'd8);
    m_ready = 1'b0;
    repeat (4) @(negedge buffer_clk);
    vec++;
    if (m_valid !== 1'b1 || m_data !== 16'h1020) begin
      bad++;
      $display("FAIL rst_mid pre: got v=%b d=%h want v=1 d=1020", m_valid, m_data);
    end
    #2 buffer_rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    @(negedge buffer_clk);
    buffer_rst_n = 1'b1;
    m_ready = 1'b1;
    start_cmd(8'h10, 9'd4);
    collect("post_rst", 8'h10, 4, 1'b0, 0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_start_while_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish by 200000");
    $fatal(1);
  end

endmodule
